stage2_hazard_unit: RTL

- Decode-stage (stage 2) stall/bubble generator: the producer-side complement of the stage-3 operand forwarding logic.
- Detects the hazards that forwarding cannot resolve and freezes or bubbles the pipeline until the forwarding paths can supply the operand:
  - load-use on a stage-3 load
  - multi-cycle DIV/REM occupying EX
  - data-memory wait
- Sits beside the IF/ID and ID/EX pipeline registers; its outputs drive PC, IF/ID and ID/EX enables and the ID/EX flush.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/hazard_div_counter.sv | 40 ++++
 rtl/stage2_hazard_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the stage-2 hazard unit.
//   hz_state_e : hazard FSM state encoding
//   REG_X0     : index of the hard-wired zero register
//   reg_match  : true when a used source register equals the stage-3 rd (x0 excluded)
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    LOAD_STALL = 2'b01,
    DIV_WAIT   = 2'b10,
    MEM_WAIT   = 2'b11
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic logic reg_match(input logic       uses,
                                     input logic [4:0] id_addr,
                                     input logic [4:0] s3_addr);
    return uses && (id_addr == s3_addr) && (id_addr != REG_X0);
  endfunction

endpackage

// File: rtl/hazard_div_counter.sv
// Loadable down-counter timing a multi-cycle divide in EX.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset (clears count)
//   freeze_i   : hold the count (takes precedence over load/decrement)
//   load_i     : load load_val_i
//   load_val_i : value loaded at divide issue
//   dec_i      : decrement by one (saturates at zero)
//   cnt_o      : current count
//   zero_o     : count is zero
module hazard_div_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             freeze_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (freeze_i)                           cnt_d = cnt_q;
    else if (load_i)                        cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))        cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/stage2_hazard_unit.sv
// Decode-stage stall/bubble generator. Freezes or bubbles the front of the
// pipeline for hazards forwarding cannot cover: load-use on a stage-3 load,
// a multi-cycle divide occupying EX, and a data-memory wait.
//
// state      | meaning
// IDLE       | no hazard in progress; divide issue / load-use detected here
// LOAD_STALL | one bubble inserted, load now in stage 4 and forwardable
// DIV_WAIT   | divide occupying EX, counting down
// MEM_WAIT   | memory busy; saved state held in resume_q
//
// Ports:
//   CLK, RESET (sync active-low)
//   ID_* : stage-2 instruction source operands
//   STAGE_3_* : stage-3 destination, load flag, divide issue
//   MEM_BUSY : data memory not ready
//   PC_STALL, IF_ID_STALL, ID_EX_BUBBLE, EX_STALL, MEM_STALL, DIV_BUSY : controls
module stage2_hazard_unit
  import cpu_pkg::*;
#(
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ID_VALID,
  input  logic [4:0] ID_ADDR1,
  input  logic [4:0] ID_ADDR2,
  input  logic       ID_USES_RS1,
  input  logic       ID_USES_RS2,
  input  logic [4:0] STAGE_3_ADDR,
  input  logic       STAGE_3_REGWRITE_EN,
  input  logic       STAGE_3_MEM_READ,
  input  logic       STAGE_3_DIV_START,
  input  logic       MEM_BUSY,
  output logic       PC_STALL,
  output logic       IF_ID_STALL,
  output logic       ID_EX_BUBBLE,
  output logic       EX_STALL,
  output logic       MEM_STALL,
  output logic       DIV_BUSY
);

  if (DIV_LATENCY < 2 || DIV_LATENCY > 63) begin : g_bad_latency
    $error("stage2_hazard_unit: DIV_LATENCY must be 2..63");
  end
  if ((DIV_LATENCY - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("stage2_hazard_unit: CNT_W too narrow for DIV_LATENCY-1");
  end

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  hz_state_e        state_q, state_d;
  hz_state_e        resume_q, resume_d;
  hz_state_e        eff_state;
  logic             load_use;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt;

  // While memory is busy the register shows MEM_WAIT; the real state lives in resume_q.
  assign eff_state = (state_q == MEM_WAIT) ? resume_q : state_q;

  assign load_use = ID_VALID && STAGE_3_REGWRITE_EN && STAGE_3_MEM_READ &&
                    (reg_match(ID_USES_RS1, ID_ADDR1, STAGE_3_ADDR) ||
                     reg_match(ID_USES_RS2, ID_ADDR2, STAGE_3_ADDR));

  assign cnt_load = !MEM_BUSY && (eff_state == IDLE) && STAGE_3_DIV_START;
  assign cnt_dec  = !MEM_BUSY && (eff_state == DIV_WAIT);

  hazard_div_counter #(.CNT_W(CNT_W)) u_div_cnt (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .freeze_i   (MEM_BUSY),
    .load_i     (cnt_load),
    .load_val_i (DIV_LOAD),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= IDLE;
      resume_q <= IDLE;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
    end
  end

  always_comb begin
    state_d  = eff_state;
    resume_d = resume_q;
    if (MEM_BUSY) begin
      state_d  = MEM_WAIT;
      resume_d = eff_state;
    end else begin
      case (eff_state)
        IDLE: begin
          if (STAGE_3_DIV_START) state_d = DIV_WAIT;
          else if (load_use)     state_d = LOAD_STALL;
          else                   state_d = IDLE;
        end
        LOAD_STALL: state_d = IDLE;
        DIV_WAIT: begin
          // Zero is unreachable in normal flow; treat it as terminal too.
          if (cnt_zero || (cnt == CNT_W'(1))) state_d = IDLE;
          else                                state_d = DIV_WAIT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    PC_STALL     = 1'b0;
    IF_ID_STALL  = 1'b0;
    ID_EX_BUBBLE = 1'b0;
    EX_STALL     = 1'b0;
    MEM_STALL    = 1'b0;
    DIV_BUSY     = 1'b0;
    if (MEM_BUSY) begin
      MEM_STALL   = 1'b1;
      PC_STALL    = 1'b1;
      IF_ID_STALL = 1'b1;
      EX_STALL    = 1'b1;
      DIV_BUSY    = (eff_state == DIV_WAIT);
    end else begin
      case (eff_state)
        IDLE: begin
          if (STAGE_3_DIV_START) begin
            DIV_BUSY    = 1'b1;
            EX_STALL    = 1'b1;
            PC_STALL    = 1'b1;
            IF_ID_STALL = 1'b1;
          end else if (load_use) begin
            PC_STALL     = 1'b1;
            IF_ID_STALL  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
          end
        end
        DIV_WAIT: begin
          DIV_BUSY    = 1'b1;
          EX_STALL    = 1'b1;
          PC_STALL    = 1'b1;
          IF_ID_STALL = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
